// File: rtl/attention_score_reader.sv
// attention_score_reader: sweeps the T x T score port in row-major order under
// a credit limit, tags each returned word, buffers it in a small FIFO and
// streams it downstream with its (q,k) position and the running row maximum.
module attention_score_reader #(
  parameter  int unsigned T          = 8,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned T_W        = (T <= 1) ? 1 : $clog2(T)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sc_re,
  output logic [T_W-1:0]    o_sc_tq,
  output logic [T_W-1:0]    o_sc_tk,
  input  logic [DATA_W-1:0] i_scm_rdata,
  input  logic              i_scm_rvalid,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [T_W-1:0]    o_out_tq,
  output logic [T_W-1:0]    o_out_tk,
  output logic              o_out_last_col,
  output logic              o_out_last,
  output logic [31:0]       o_out_row_max,
  output logic              o_err_proto
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = DATA_W + 2 * T_W;

  localparam logic [T_W-1:0]    LAST_IDX = T_W'(T - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] NAN_SUB  = DATA_W'(32'h7FC0_0000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [T_W-1:0]    r_q;
  logic [T_W-1:0]    r_k;
  logic              r_inflight;
  logic [T_W-1:0]    r_tag_q;
  logic [T_W-1:0]    r_tag_k;
  logic              r_rst_d;
  logic              r_err;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_acc;

  logic              w_busy;
  logic              w_done;
  logic              w_issue;
  logic              w_last_issue;
  logic [CNT_W:0]    w_used;
  logic              w_credit;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] w_push_data;
  logic              w_proto_err;
  logic [ENT_W-1:0]  w_head;
  logic [DATA_W-1:0] w_head_data;
  logic [T_W-1:0]    w_head_tq;
  logic [T_W-1:0]    w_head_tk;
  logic [31:0]       w_head_data32;
  logic [31:0]       w_head_max;
  logic [31:0]       w_row_max;

  // Total order on FP32 bit patterns as an unsigned key.
  function automatic logic [31:0] f_key(input logic [31:0] a);
    return a[31] ? ~a : (a ^ 32'h8000_0000);
  endfunction

  // Circular pointer increment for arbitrary depths.
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: FIFO entries plus the outstanding read must stay below depth.
  assign w_used       = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
  assign w_credit     = (w_used < DEPTH_C);
  assign w_last_issue = w_issue && (r_q == LAST_IDX) && (r_k == LAST_IDX);

  // Every issued read produces exactly one push the following cycle.
  assign w_push       = r_inflight;
  assign w_push_data  = i_scm_rvalid ? i_scm_rdata : NAN_SUB;
  assign w_proto_err  = (r_inflight && !i_scm_rvalid) ||
                        (i_scm_rvalid && !r_inflight && !r_rst_d);

  assign w_empty      = (r_count == '0);
  assign w_pop        = !w_empty && i_out_ready;
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_head        = r_mem[r_rptr];
  assign w_head_data   = w_head[ENT_W-1 -: DATA_W];
  assign w_head_tq     = w_head[2*T_W-1 -: T_W];
  assign w_head_tk     = w_head[T_W-1:0];
  assign w_head_data32 = 32'(w_head_data);
  assign w_head_max    = (f_key(w_head_data32) > f_key(r_acc)) ? w_head_data32 : r_acc;
  assign w_row_max     = (w_head_tk == '0) ? w_head_data32 : w_head_max;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; DRAIN exits once the FIFO will be empty after this edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_count_nxt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      S_RUN: begin
        w_busy  = 1'b1;
        w_issue = w_credit;
      end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Row-major issue counters; hold on the final read so sc_tq/sc_tk keep it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      r_k <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_q <= '0;
      r_k <= '0;
    end else if (w_issue && !w_last_issue) begin
      if (r_k == LAST_IDX) begin
        r_k <= '0;
        r_q <= r_q + T_W'(1);
      end else begin
        r_k <= r_k + T_W'(1);
      end
    end
  end

  // Outstanding-read tag and sticky protocol error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inflight <= 1'b0;
      r_tag_q    <= '0;
      r_tag_k    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag_q <= r_q;
        r_tag_k <= r_k;
      end
      if (w_proto_err) r_err <= 1'b1;
    end
  end

  // Marks the cycle after reset, when a stale return must be dropped silently.
  always_ff @(posedge i_clk) begin
    r_rst_d <= i_rst;
  end

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {w_push_data, r_tag_q, r_tag_k};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
      r_count <= w_count_nxt;
    end
  end

  // Pop-side row maximum accumulator.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (w_pop) begin
      r_acc <= w_row_max;
    end
  end

  assign o_busy         = w_busy;
  assign o_done         = w_done;
  assign o_sc_re        = w_issue;
  assign o_sc_tq        = r_q;
  assign o_sc_tk        = r_k;
  assign o_err_proto    = r_err;
  assign o_out_valid    = !w_empty;
  assign o_out_data     = w_empty ? '0 : w_head_data;
  assign o_out_tq       = w_empty ? '0 : w_head_tq;
  assign o_out_tk       = w_empty ? '0 : w_head_tk;
  assign o_out_last_col = !w_empty && (w_head_tk == LAST_IDX);
  assign o_out_last     = !w_empty && (w_head_tk == LAST_IDX) && (w_head_tq == LAST_IDX);
  assign o_out_row_max  = w_empty ? '0 : w_row_max;

endmodule

// File: tb/tb_attention_score_reader.sv
// Bench for attention_score_reader: directed sweeps against a queue-free
// positional model of the expected beat stream and row maxima.
module tb_attention_score_reader;

  localparam int T     = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_sc_re;
  logic [2:0]  o_sc_tq;
  logic [2:0]  o_sc_tk;
  logic [31:0] i_scm_rdata;
  logic        i_scm_rvalid;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic [2:0]  o_out_tq;
  logic [2:0]  o_out_tk;
  logic        o_out_last_col;
  logic        o_out_last;
  logic [31:0] o_out_row_max;
  logic        o_err_proto;

  attention_score_reader #(.T(8), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_sc_re       (o_sc_re),
    .o_sc_tq       (o_sc_tq),
    .o_sc_tk       (o_sc_tk),
    .i_scm_rdata   (i_scm_rdata),
    .i_scm_rvalid  (i_scm_rvalid),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_out_tq      (o_out_tq),
    .o_out_tk      (o_out_tk),
    .o_out_last_col(o_out_last_col),
    .o_out_last    (o_out_last),
    .o_out_row_max (o_out_row_max),
    .o_err_proto   (o_err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mat [T][T];
  int wq = -1, wk = -1;

  int exp_total = 0, exp_idx = 0;
  int rel = -1000;
  bit arm = 0;
  int n_re = 0, n_pop = 0;
  int re_cnt, last_re_rel, first_beat_rel, last_beat_rel;
  int done_cnt, done_rel, beat_cnt;
  bit busy1, busy_done, err_seen;
  int err_rel, wh_rel;
  logic [31:0] cap_rm2, cap_rm5, cap_34;
  bit nx_rvalid = 0;
  logic [31:0] nx_rdata = '0;
  bit spur_req = 0;
  int ready_mode = 0;
  int pc = 0;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int expv);
    n_tests++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic logic [31:0] fkey(input logic [31:0] a);
    return a[31] ? ~a : (a ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] exp_data(input int q, input int k);
    if (q == wq && k == wk) return 32'h7FC0_0000;
    return mat[q][k];
  endfunction

  // Maximum of row q over columns 0..k, ordered by the FP32 sort key.
  function automatic logic [31:0] exp_rowmax(input int q, input int k);
    logic [31:0] m;
    m = exp_data(q, 0);
    for (int j = 1; j <= k; j++)
      if (fkey(exp_data(q, j)) > fkey(m)) m = exp_data(q, j);
    return m;
  endfunction

  function automatic logic [95:0] all_outs();
    return 96'({o_busy, o_done, o_sc_re, o_out_valid, o_out_last_col, o_out_last,
                o_err_proto, o_sc_tq, o_sc_tk, o_out_tq, o_out_tk, o_out_data,
                o_out_row_max});
  endfunction

  // Responder and ready driver: inputs change just after the rising edge.
  initial begin
    i_scm_rvalid = 1'b0;
    i_scm_rdata  = '0;
    i_out_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_scm_rvalid = nx_rvalid;
      i_scm_rdata  = nx_rdata;
      if (ready_mode == 0) begin
        i_out_ready = 1'b1;
      end else begin
        i_out_ready = (pc % 4 == 0) || (pc % 4 == 3);
        pc++;
      end
    end
  end

  // Monitor: samples mid-cycle, plans responses and checks every beat.
  initial begin : mon
    int q, k;
    logic [95:0] gotv, expv;
    forever begin
      @(negedge clk);
      rel++;
      if (arm && i_start) begin
        rel = 0;
        arm = 0;
      end
      nx_rvalid = 1'b0;
      nx_rdata  = '0;
      if (o_sc_re) begin
        if (int'(o_sc_tq) == wq && int'(o_sc_tk) == wk) begin
          nx_rdata = 32'hDEAD_BEEF;
          wh_rel   = rel + 1;
        end else begin
          nx_rvalid = 1'b1;
          nx_rdata  = mat[o_sc_tq][o_sc_tk];
        end
      end else if (spur_req) begin
        nx_rvalid = 1'b1;
        nx_rdata  = 32'h1234_5678;
      end
      if (i_rst) begin
        exp_total = 0;
        exp_idx   = 0;
        n_re      = 0;
        n_pop     = 0;
      end else begin
        if (o_busy) begin
          chk("credit_bound", 96'(n_re - n_pop <= DEPTH), 96'd1);
          if (n_re - n_pop == DEPTH) chk("credit_stall", 96'(o_sc_re), 96'd0);
        end
        if (o_sc_re) begin
          n_re++;
          re_cnt++;
          last_re_rel = rel;
        end
        if (rel == 1) busy1 = o_busy;
        if (o_done) begin
          done_cnt++;
          done_rel  = rel;
          busy_done = o_busy;
        end
        if (o_err_proto && !err_seen) begin
          err_seen = 1;
          err_rel  = rel;
        end
        if (o_out_valid) begin
          if (exp_idx >= exp_total) begin
            chk("unexpected_beat", 96'(o_out_valid), 96'd0);
          end else begin
            q = exp_idx / T;
            k = exp_idx % T;
            gotv = {o_out_data, o_out_row_max, 8'(o_out_tq), 8'(o_out_tk),
                    7'd0, o_out_last_col, 7'd0, o_out_last};
            expv = {exp_data(q, k), exp_rowmax(q, k), 8'(q), 8'(k),
                    7'd0, (k == T - 1), 7'd0, (q == T - 1 && k == T - 1)};
            chk("beat", gotv, expv);
          end
          if (i_out_ready) begin
            n_pop++;
            beat_cnt++;
            if (first_beat_rel < 0) first_beat_rel = rel;
            last_beat_rel = rel;
            if (o_out_tq == 3'd2 && o_out_tk == 3'd7) cap_rm2 = o_out_row_max;
            if (o_out_tq == 3'd5 && o_out_tk == 3'd7) cap_rm5 = o_out_row_max;
            if (o_out_tq == 3'd3 && o_out_tk == 3'd4) cap_34  = o_out_data;
            if (exp_idx < exp_total) exp_idx++;
          end
        end
      end
    end
  end

  // Arms the model and pulses start; returns in cycle 1 of the sweep.
  task automatic start_sweep();
    @(posedge clk);
    #1;
    exp_total = T * T;
    exp_idx = 0;
    re_cnt = 0; last_re_rel = -1; first_beat_rel = -1; last_beat_rel = -1;
    done_cnt = 0; done_rel = -1; beat_cnt = 0;
    busy1 = 0; busy_done = 1; err_seen = 0; err_rel = -1; wh_rel = -100;
    arm = 1;
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk_i("done_seen", int'(done_cnt > 0), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] row2 [T];
    row2 = '{32'hFF800000, 32'hFF800000, 32'hBF800000, 32'h40200000,
             32'hC0000000, 32'h3F800000, 32'hFF800000, 32'h00000000};
    for (int q = 0; q < T; q++)
      for (int k = 0; k < T; k++) mat[q][k] = 32'(q * T + k);
    i_rst = 1'b1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", all_outs(), 96'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;

    // Full sweep with stray start pulses in cycles 5 and 20.
    start_sweep();
    repeat (4) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (14) @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done(300);
    chk_i("a_done_cycle", done_rel, 67);
    chk_i("a_done_count", done_cnt, 1);
    chk_i("a_re_count", re_cnt, 64);
    chk_i("a_last_re_cycle", last_re_rel, 64);
    chk_i("a_first_beat_cycle", first_beat_rel, 3);
    chk_i("a_last_beat_cycle", last_beat_rel, 66);
    chk_i("a_busy_cycle1", int'(busy1), 1);
    chk_i("a_busy_at_done", int'(busy_done), 0);
    chk_i("a_beats", beat_cnt, 64);
    chk_i("a_err", int'(o_err_proto), 0);

    // Row maxima with infinities and negatives.
    for (int k = 0; k < T; k++) begin
      mat[2][k] = row2[k];
      mat[5][k] = 32'hFF800000;
    end
    start_sweep();
    wait_done(300);
    chk("b_rowmax2", 96'(cap_rm2), 96'h40200000);
    chk("b_rowmax5", 96'(cap_rm5), 96'hFF800000);
    chk_i("b_beats", beat_cnt, 64);
    chk_i("b_err", int'(o_err_proto), 0);

    // Backpressure 1,0,0,1 plus a withheld return for (3,4).
    wq = 3;
    wk = 4;
    ready_mode = 1;
    start_sweep();
    wait_done(800);
    chk("c_nan_beat", 96'(cap_34), 96'h7FC00000);
    chk_i("c_err_rise", err_rel, wh_rel + 1);
    chk_i("c_err", int'(o_err_proto), 1);
    chk_i("c_beats", beat_cnt, 64);
    chk_i("c_done_count", done_cnt, 1);

    // Spurious return while idle.
    ready_mode = 0;
    wq = -1;
    wk = -1;
    do_reset();
    @(negedge clk);
    chk_i("d_err_cleared", int'(o_err_proto), 0);
    beat_cnt = 0;
    @(posedge clk);
    #1 spur_req = 1;
    @(posedge clk);
    #1 spur_req = 0;
    repeat (3) @(negedge clk);
    chk_i("d_err_spurious", int'(o_err_proto), 1);
    chk_i("d_no_beat", beat_cnt, 0);

    // Reset in cycle 30 of a sweep, then a clean sweep.
    do_reset();
    start_sweep();
    repeat (29) @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("e_outputs_after_rst", all_outs(), 96'd0);
    repeat (3) @(negedge clk);
    chk_i("e_err_after_rst", int'(o_err_proto), 0);
    start_sweep();
    wait_done(300);
    chk_i("e_beats", beat_cnt, 64);
    chk_i("e_done_cycle", done_rel, 67);
    chk_i("e_done_count", done_cnt, 1);
    chk_i("e_err", int'(o_err_proto), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/attention_score_reader.md
# attention_score_reader

Read-side initiator for the scaled/masked score readout port of the attention pre-softmax stage (sc_re/sc_tq/sc_tk in, scm_rdata/scm_rvalid out, fixed 1-cycle read latency). After a start pulse it sweeps the T×T score matrix in row-major order, tags and buffers the returned words, and streams them to the softmax stage over a valid/ready interface. Each beat carries its (q,k) position, and the last beat of each row also carries that row's FP32 maximum. Read issue is credit-limited, so downstream backpressure never loses data.

## Interface
- T, 8, sequence length; matrix is T×T
- DATA_W, 32, score word width (FP32)
- FIFO_DEPTH, 4, output buffer entries; must be ≥2
- T_W, derived, (T<=1)?1:$clog2(T)
- clk, input, 1, sole clock, rising edge
- rst, input, 1, synchronous, active-high reset
- start, input, 1, begin sweep; sampled only in IDLE
- busy, output, 1, high from the cycle after start is accepted until done
- done, output, 1, one-cycle completion pulse
- sc_re, output, 1, read request to the score port
- sc_tq, output, T_W, requested query row
- sc_tk, output, T_W, requested key column
- scm_rdata, input, DATA_W, returned score
- scm_rvalid, input, 1, return strobe, exactly 1 cycle after sc_re
- out_valid, output, 1, beat available
- out_ready, input, 1, downstream accept
- out_data, output, DATA_W, score word
- out_tq, output, T_W, row of beat
- out_tk, output, T_W, column of beat
- out_last_col, output, 1, beat is tk==T-1
- out_last, output, 1, beat is (T-1,T-1)
- out_row_max, output, 32, row maximum; valid when out_valid&&out_last_col
- err_proto, output, 1, sticky protocol error flag

## Operation
- FSM states:
  - IDLE: start moves to RUN.
  - RUN: issue reads. After the read for (T-1,T-1) is issued, move to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight.
  - DONE: one cycle, done=1, then IDLE.
- start is ignored outside IDLE.
- Issue counters q,k step row-major: k increments, wraps T-1→0, then q increments. Counters clear on entering RUN.
- Credit rule: sc_re=1 only in RUN when fifo_count + inflight < FIFO_DEPTH.
  - inflight is a 1-bit flag holding the tag (q,k) of the last request.
  - When credits are not available, sc_re=0 and the counters hold.
- Return path (cycle after sc_re):
  - If scm_rvalid=1: push {scm_rdata, tag} to the FIFO.
  - If scm_rvalid=0: push {32'h7FC00000, tag} and set err_proto, so the sweep still completes.
  - If scm_rvalid=1 with no request outstanding: drop the word and set err_proto.
- FIFO:
  - out_* fields are driven from the head entry; out_valid = !empty.
  - A beat is popped when out_valid&&out_ready.
  - Simultaneous push and pop is legal at any occupancy, including full.
- Row max is tracked on the pop side.
  - Compare key: a[31] ? ~a : a^32'h80000000, unsigned.
  - On a popped beat with tk==0, acc ← data; otherwise acc ← max(acc, data).
  - out_row_max is combinational: data when tk==0, else max(acc, data). It therefore includes the current beat.
  - 32'hFF800000 (−inf) orders below every finite value. The NaN substitute is compared by key with no special casing.
- err_proto clears only on rst. It does not stop the sweep.
- Reset mid-operation: go to IDLE; clear FIFO, inflight, counters, acc and err_proto. Any in-flight return arriving the cycle after reset is ignored without flagging.

## Timing
- Reset values:
  - busy, done, sc_re, out_valid, out_last_col, out_last, err_proto = 0.
  - sc_tq, sc_tk, out_data, out_tq, out_tk, out_row_max = 0.
- Cycle numbering: cycle n is the n-th cycle after the edge that samples start. With out_ready held at 1:
  - busy=1 and sc_re for (0,0) in cycle 1.
  - Data returns in cycle 2; out_valid for (0,0) in cycle 3.
  - Steady state: one read and one beat per cycle.
- T=8 sweep: last sc_re in cycle 64, last beat in cycle 66, done=1 and busy=0 in cycle 67, IDLE in cycle 68.
- sc_tq and sc_tk are registered and stable whenever sc_re=1. They hold their last value when sc_re=0.
- While out_valid=1 and out_ready=0, all out_* fields stay stable.
- done follows the final handshake by exactly one cycle.

## Test plan
- T=8, out_ready=1, responder returns data=q*8+k as an integer:
  - 64 beats in row-major order.
  - out_last_col on every k=7 beat; out_last only on (7,7).
  - done high only in cycle 67; exactly 64 sc_re pulses.
- Row-max values:
  - Row 2 = {FF800000, FF800000, BF800000, 40200000, C0000000, 3F800000, FF800000, 00000000} → out_row_max=40200000 on the (2,7) beat.
  - Row 5 all FF800000 → out_row_max=FF800000.
- Backpressure, out_ready = 1,0,0,1 repeating:
  - All 64 beats arrive intact and in order.
  - fifo_count+inflight never exceeds 4.
  - sc_re=0 whenever credits are full; out_* stable during stalls.
- Withhold scm_rvalid for the (3,4) read:
  - err_proto rises the following cycle.
  - The (3,4) beat carries 7FC00000; the sweep finishes with done.
- scm_rvalid pulsed while IDLE → err_proto=1, no beat emitted.
- Protocol and reset checks:
  - start pulsed in cycles 5 and 20 of a sweep → ignored, exactly one done.
  - rst asserted at cycle 30 → all outputs 0 the next cycle.
  - A fresh start then completes a full 64-beat sweep with err_proto=0.
